// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: redirect FSM state encoding and default register indices
//   shared by pipeline_hazard_ctrl and its testbench.
package pipeline_hazard_ctrl_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;
    localparam int REG_PC    = 0;
    localparam int REG_IFID  = 1;
    localparam int REG_IDEX  = 2;
    localparam int REG_EXMEM = 3;
    localparam int REG_MEMWB = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear, wins over inc_i
//   inc_i      : increment, holds at all-ones
//   cnt_o      : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/bubble/flush control for an NSTAGE pipeline with redirect FSM,
//   per-register stall counters and deadlock watchdog.
//   stall_req_i/flush_*_i/cnt_clr_i : hazard requests, redirect request, counter clear
//   stall_o/bubble_o/flush_o        : per-register hold, NOP-load and squash enables
//   redirect_valid_o/redirect_pc_o  : PC redirect
//   stall_cnt_o/deadlock_o/proto_err_o : statistics, watchdog and protocol error flags
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE  = 5,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    parameter int IDX_W   = $clog2(NSTAGE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSTAGE-1:0]       stall_req_i,
    input  logic                    flush_req_i,
    input  logic [IDX_W-1:0]        flush_idx_i,
    input  logic [ADDR_W-1:0]       flush_pc_i,
    input  logic                    cnt_clr_i,
    output logic [NSTAGE-1:0]       stall_o,
    output logic [NSTAGE-1:0]       bubble_o,
    output logic [NSTAGE-1:0]       flush_o,
    output logic                    redirect_valid_o,
    output logic [ADDR_W-1:0]       redirect_pc_o,
    output logic [NSTAGE*CNT_W-1:0] stall_cnt_o,
    output logic                    deadlock_o,
    output logic                    proto_err_o
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [NSTAGE-1:0] chain, flush, bubble_raw;
    logic              stall_at_idx, accept;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              proto_q, proto_d, dead_q, dead_d;
    logic [WD_W-1:0]   wd_cnt;

    always_comb begin
        chain        = '0;
        bubble_raw   = '0;
        flush        = '0;
        stall_at_idx = 1'b0;
        for (int k = 0; k < NSTAGE; k++) chain[k] = |(stall_req_i >> k);
        for (int k = 1; k < NSTAGE; k++) bubble_raw[k] = chain[k-1] & ~chain[k];
        for (int k = 0; k < NSTAGE; k++) if (int'(flush_idx_i) == k) stall_at_idx = chain[k];
        accept = flush_req_i && flush_idx_i != '0 && int'(flush_idx_i) < NSTAGE && !stall_at_idx;
        // While a redirect is pending, register 1 keeps dropping wrong-path fetches.
        for (int k = 1; k < NSTAGE; k++)
            flush[k] = (accept && k < int'(flush_idx_i)) || (k == 1 && state_q == PEND);
    end

    assign stall_o  = chain & ~flush;
    assign bubble_o = bubble_raw & ~flush;
    assign flush_o  = flush;

    // A new accepted flush always supersedes any latched target; the redirect fires
    // in the first cycle the PC register is free.
    always_comb begin
        state_d          = state_q;
        pc_d             = accept ? flush_pc_i : pc_q;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = pc_q;
        if (accept || state_q == PEND) begin
            redirect_valid_o = ~chain[0];
            redirect_pc_o    = accept ? flush_pc_i : pc_q;
            state_d          = chain[0] ? PEND : IDLE;
        end
        proto_d = proto_q | (flush_req_i & ~accept);
        dead_d  = cnt_clr_i ? 1'b0 : dead_q | (chain[0] && wd_cnt == WD_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            proto_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            proto_q <= proto_d;
            dead_q  <= dead_d;
        end
    end

    assign deadlock_o  = dead_q;
    assign proto_err_o = proto_q;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (cnt_clr_i),
            .inc_i (stall_o[g]),
            .cnt_o (stall_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    sat_counter #(.W(WD_W)) u_wd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_i | ~chain[0]),
        .inc_i (chain[0]),
        .cnt_o (wd_cnt)
    );
endmodule
